// File: rtl/pack_seq_pkg.sv
// Shared definitions for the DW-packer sequencer: FSM states, datapath widths
// and the drain timeout.
package pack_seq_pkg;

    localparam int DATA_W        = 128;
    localparam int DW_PER_BEAT   = 4;
    localparam int DRAIN_TIMEOUT = 15;
    localparam int LEN_W         = 16;
    localparam int SUM_W         = LEN_W + 2;
    localparam int TMR_W         = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pack_seq_calc.sv
// Combinational beat-count and DW-offset calculator for a DW-granular transfer
// on a 4-DW (128-bit) beat bus; shared with the other DMA channels.
module pack_seq_calc
    import pack_seq_pkg::*;
(
    input  logic [1:0]       addr_dw,
    input  logic [LEN_W-1:0] len_dw,
    output logic [1:0]       off,
    output logic [LEN_W-1:0] beats,
    output logic [1:0]       last_first_dw
);

    logic [SUM_W-1:0] total;
    logic [SUM_W-1:0] rounded;
    logic [1:0]       tail;

    // 18-bit sum so that off + 65535 cannot wrap; the ceiling division by
    // four keeps beats within LEN_W bits
    always_comb begin
        off           = addr_dw;
        total         = {{(SUM_W-2){1'b0}}, addr_dw} + {2'b00, len_dw};
        rounded       = total + SUM_W'(DW_PER_BEAT - 1);
        beats         = rounded[SUM_W-1:2];
        tail          = total[1:0];
        last_first_dw = 2'd0 - tail;
    end

endmodule

// File: rtl/pack_seq.sv
// Descriptor-driven sequencer that feeds a 128-bit DW packer.
// Optional statistics counters are enabled with the PACK_SEQ_STATS_EN macro.
module pack_seq
    import pack_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [31:0]       desc_addr,
    input  logic [LEN_W-1:0]  desc_len_dw,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] pk_din,
    output logic [1:0]        pk_first_dw,
    output logic              pk_valid,
    output logic              pk_done,
    input  logic              pk_dout_done,
    output logic              busy,
    output logic              xfer_done,
    output logic              len_err
`ifdef PACK_SEQ_STATS_EN
    ,
    output logic [31:0]       stat_xfers,
    output logic [31:0]       stat_beats,
    output logic [15:0]       stat_errs
`endif
);

    state_t           state;
    state_t           state_n;
    logic [LEN_W-1:0] beats_left;
    logic [TMR_W-1:0] drain_tmr;
    logic             first_beat;
    logic [1:0]       off_q;
    logic [1:0]       last_fd_q;

    logic [1:0]       calc_off;
    logic [LEN_W-1:0] calc_beats;
    logic [1:0]       calc_last_fd;
    logic             accept;
    logic             drain_expired;
    logic             unused_addr;

    assign unused_addr = ^{desc_addr[31:4], desc_addr[1:0]};

    pack_seq_calc u_calc (
        .addr_dw       (desc_addr[3:2]),
        .len_dw        (desc_len_dw),
        .off           (calc_off),
        .beats         (calc_beats),
        .last_first_dw (calc_last_fd)
    );

    assign accept        = desc_valid && desc_ready;
    assign drain_expired = (drain_tmr == TMR_W'(DRAIN_TIMEOUT - 1));
    assign pk_din        = s_data;

    // A single-beat transfer has first_beat and beats_left==1 together, so the
    // first-beat offset takes priority over the last-beat unused count.
    always_comb begin
        state_n     = state;
        desc_ready  = (state == IDLE);
        s_ready     = (state == RUN);
        busy        = (state != IDLE);
        pk_valid    = s_valid && s_ready;
        pk_done     = pk_valid && (beats_left == LEN_W'(1));
        pk_first_dw = 2'd0;
        if (state == RUN) begin
            if (first_beat)
                pk_first_dw = off_q;
            else if (beats_left == LEN_W'(1))
                pk_first_dw = last_fd_q;
        end
        case (state)
            IDLE:    if (accept && desc_len_dw != '0) state_n = RUN;
            RUN:     if (pk_done) state_n = DRAIN;
            DRAIN:   if (pk_dout_done || drain_expired) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            beats_left <= '0;
            drain_tmr  <= '0;
            first_beat <= 1'b0;
            off_q      <= 2'd0;
            last_fd_q  <= 2'd0;
            xfer_done  <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state     <= state_n;
            xfer_done <= (state == DRAIN) && pk_dout_done;
            len_err   <= (accept && desc_len_dw == '0) ||
                         ((state == DRAIN) && !pk_dout_done && drain_expired);
            drain_tmr <= ((state == DRAIN) && (state_n == DRAIN)) ? drain_tmr + 1'b1 : '0;
            if (accept) begin
                beats_left <= calc_beats;
                off_q      <= calc_off;
                last_fd_q  <= calc_last_fd;
                first_beat <= 1'b1;
            end else if (pk_valid) begin
                beats_left <= beats_left - 1'b1;
                first_beat <= 1'b0;
            end
        end
    end

`ifdef PACK_SEQ_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stat_xfers <= '0;
            stat_beats <= '0;
            stat_errs  <= '0;
        end else begin
            if (xfer_done) stat_xfers <= stat_xfers + 1'b1;
            if (pk_valid)  stat_beats <= stat_beats + 1'b1;
            if (len_err)   stat_errs  <= stat_errs + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pack_seq.md
PACK_SEQ -- requirements
Module: pack_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: i_clk in 1, rising-edge clock; i_rst in 1, reset.
REQ-002 desc_valid in 1: a transfer descriptor is offered.
REQ-003 desc_ready out 1: the descriptor is accepted when high together with desc_valid.
REQ-004 desc_addr in 32: byte address of the first DW; bits [1:0] are ignored.
REQ-005 desc_len_dw in 16: transfer length in DWs; 0 is illegal.
REQ-006 s_data in 128, s_valid in 1, s_ready out 1: source beat stream; a beat transfers when s_valid and s_ready are both high.
REQ-007 pk_din out 128, pk_first_dw out 2, pk_valid out 1, pk_done out 1: drive to the downstream 128-bit DW packer.
REQ-008 pk_dout_done in 1: the packer's one-cycle final-output flag.
REQ-009 busy out 1; xfer_done out 1 (pulse); len_err out 1 (pulse).

Function
REQ-010 The state machine SHALL have states IDLE, RUN and DRAIN.
REQ-011 desc_ready SHALL be high only in IDLE.
REQ-012 On acceptance with desc_len_dw != 0, the block SHALL latch off = desc_addr[3:2] and beats = ceil((off + len) / 4), set tail = (off + len) mod 4, and move to RUN on the next cycle.
REQ-013 On acceptance with desc_len_dw == 0, the block SHALL pulse len_err for one cycle, stay in IDLE, and emit no beats.
REQ-014 s_ready SHALL equal (state == RUN); pk_din SHALL equal s_data combinationally; pk_valid SHALL equal s_valid && s_ready, with zero latency.
REQ-015 A beats_left counter, loaded with beats, SHALL decrement on every transferred beat.
REQ-016 pk_done SHALL equal pk_valid && (beats_left == 1).
REQ-017 pk_first_dw SHALL be off on the first beat of a transfer.
REQ-018 On the last beat of a multi-beat transfer, pk_first_dw SHALL be (4 - tail) mod 4, the count of unused upper DWs.
REQ-019 For a single-beat transfer (beats == 1), pk_first_dw SHALL be off, and the first and last beat are the same beat.
REQ-020 On a middle beat, pk_first_dw SHALL be 0.
REQ-021 After the last beat transfers, the next state SHALL be DRAIN, with s_ready low from that next cycle.
REQ-022 In DRAIN, the block SHALL wait for pk_dout_done, then pulse xfer_done in the following cycle and return to IDLE.
REQ-023 In DRAIN, a drain timer SHALL count cycles; at 15 cycles it SHALL force IDLE and pulse len_err.
REQ-024 pk_valid SHALL never be high in IDLE or DRAIN.
REQ-025 pk_done SHALL never be high without pk_valid.
REQ-026 busy SHALL be (state != IDLE).
REQ-027 A gap in s_valid during RUN SHALL hold all counters, with no effect on the packer.
REQ-028 A pk_dout_done arriving outside DRAIN SHALL be ignored.
REQ-029 Length arithmetic SHALL be 18-bit to cover off + 65535 without wrap.

Reset
REQ-030 i_rst SHALL force the following, regardless of state: state IDLE, beats_left 0, drain timer 0, desc_ready 1, s_ready 0, pk_valid 0, pk_done 0, pk_first_dw 0, busy 0, xfer_done 0, len_err 0.
REQ-031 Reset mid-RUN SHALL drop the transfer with no pk_done issued; the packer shares i_rst.

Configuration
REQ-032 With PACK_SEQ_STATS_EN defined, the block SHALL add outputs stat_xfers (32-bit count of xfer_done pulses), stat_beats (32-bit count of transferred beats) and stat_errs (16-bit count of len_err pulses).
REQ-033 The statistics counters SHALL wrap naturally and clear on i_rst.
REQ-034 Without PACK_SEQ_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE/RUN/DRAIN), DATA_W=128, DW_PER_BEAT=4, DRAIN_TIMEOUT=15 and LEN_W=16.
REQ-036 The beat-count and first_dw/tail computation SHALL be one combinational sub-module, pack_seq_calc, reused by other DMA channels.
REQ-037 Control SHALL stay in pack_seq.

Verification
REQ-038 Scenario addr=0x0, len=8, 2 beats back-to-back: pk_first_dw = 0,0; pk_done on beat 2; pk_dout_done at T -> xfer_done at T+1.
REQ-039 Scenario addr=0x4, len=6: beats=2; beat 1 pk_first_dw=1; beat 2 pk_first_dw=(4-3)=1 with pk_done; s_ready low in the cycle after beat 2.
REQ-040 Scenario addr=0xC, len=1: one beat with pk_first_dw=3 and pk_done=1; no further s_ready.
REQ-041 Scenario len=0: len_err pulses once, busy stays 0, pk_valid stays 0; a following descriptor addr=0x8, len=4 gives beats=2 and last pk_first_dw=2.
REQ-042 Scenario addr=0x0, len=12, with s_valid deasserted 3 cycles between beats 1 and 2: exactly 3 pk_valid pulses, pk_done only on the third.
REQ-043 Scenario pk_dout_done never returned: len_err pulses 15 cycles after entering DRAIN and the block returns to IDLE; i_rst asserted mid-RUN of len=16 -> all outputs at reset values next cycle and no pk_done.
